// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: 32-bit IPv4 word stream in, GMII byte stream out.
// Adds preamble/SFD, MAC header, zero pad, CRC-32 FCS and inter-frame gap.
module eth_tx_framer #(
  parameter int          MAX_PAYLOAD = 1500,
  parameter logic [15:0] ETHERTYPE   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] mac_dst,
  input  logic [47:0] mac_src,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [1:0]  in_last_bytes,
  output logic        in_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_aborted
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, ABORT, DRAIN, IFG
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_CNT = 11'd46;

  // Registered state describes the byte currently on the GMII wire.
  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [31:0] hold_reg, hold_next;
  logic        hold_last_reg, hold_last_next;
  logic [1:0]  hold_lb_reg, hold_lb_next;
  logic [10:0] pay_cnt_reg, pay_cnt_next;
  logic        last_seen_reg, last_seen_next;
  logic [47:0] mac_dst_reg, mac_dst_next;
  logic [47:0] mac_src_reg, mac_src_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] frames_sent_reg, frames_sent_next;
  logic [15:0] frames_aborted_reg, frames_aborted_next;
  logic [7:0]  gmii_txd_reg, gmii_txd_next;
  logic        gmii_tx_en_reg, gmii_tx_en_next;
  logic        gmii_tx_er_reg, gmii_tx_er_next;
  logic [1:0]  last_idx;
  logic [31:0] fcs;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [47:0] dst,
                                          input logic [47:0] src);
    case (idx)
      4'd0:    return dst[47:40];
      4'd1:    return dst[39:32];
      4'd2:    return dst[31:24];
      4'd3:    return dst[23:16];
      4'd4:    return dst[15:8];
      4'd5:    return dst[7:0];
      4'd6:    return src[47:40];
      4'd7:    return src[39:32];
      4'd8:    return src[31:24];
      4'd9:    return src[23:16];
      4'd10:   return src[15:8];
      4'd11:   return src[7:0];
      4'd12:   return ETHERTYPE[15:8];
      default: return ETHERTYPE[7:0];
    endcase
  endfunction

  // in_last_bytes of 0 wraps to index 3, i.e. all four bytes valid.
  assign last_idx = hold_last_reg ? (hold_lb_reg - 2'd1) : 2'd3;

  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    byte_idx_next       = byte_idx_reg;
    hold_next           = hold_reg;
    hold_last_next      = hold_last_reg;
    hold_lb_next        = hold_lb_reg;
    pay_cnt_next        = pay_cnt_reg;
    last_seen_next      = last_seen_reg;
    mac_dst_next        = mac_dst_reg;
    mac_src_next        = mac_src_reg;
    crc_next            = crc_reg;
    frames_sent_next    = frames_sent_reg;
    frames_aborted_next = frames_aborted_reg;
    in_ready            = 1'b0;

    if (state_reg == HEADER || state_reg == PAYLOAD || state_reg == PAD) begin
      crc_next = crc32_byte(crc_reg, gmii_txd_reg);
    end

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next   = PREAMBLE;
          cnt_next     = 4'd0;
          mac_dst_next = mac_dst;
          mac_src_next = mac_src;
        end
      end
      PREAMBLE: begin
        if (cnt_reg == 4'd6) state_next = SFD;
        else                 cnt_next   = cnt_reg + 4'd1;
      end
      SFD: begin
        state_next     = HEADER;
        cnt_next       = 4'd0;
        crc_next       = 32'hFFFFFFFF;
        pay_cnt_next   = 11'd0;
        last_seen_next = 1'b0;
      end
      HEADER: begin
        if (cnt_reg == 4'd13) begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_next     = PAYLOAD;
            hold_next      = in_data;
            hold_last_next = in_last;
            hold_lb_next   = in_last_bytes;
            last_seen_next = in_last;
            byte_idx_next  = 2'd0;
            pay_cnt_next   = 11'd1;
          end else begin
            state_next = ABORT;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      PAYLOAD: begin
        if (byte_idx_reg != last_idx) begin
          if (pay_cnt_reg == MAX_CNT) begin
            state_next = ABORT;
          end else begin
            byte_idx_next = byte_idx_reg + 2'd1;
            pay_cnt_next  = pay_cnt_reg + 11'd1;
          end
        end else if (!hold_last_reg) begin
          in_ready = 1'b1;
          if (!in_valid) begin
            state_next = ABORT;
          end else begin
            hold_next      = in_data;
            hold_last_next = in_last;
            hold_lb_next   = in_last_bytes;
            last_seen_next = in_last;
            if (pay_cnt_reg == MAX_CNT) begin
              state_next = ABORT;
            end else begin
              byte_idx_next = 2'd0;
              pay_cnt_next  = pay_cnt_reg + 11'd1;
            end
          end
        end else if (pay_cnt_reg < MIN_CNT) begin
          state_next   = PAD;
          pay_cnt_next = pay_cnt_reg + 11'd1;
        end else begin
          state_next = FCS;
          cnt_next   = 4'd0;
        end
      end
      PAD: begin
        if (pay_cnt_reg == MIN_CNT) begin
          state_next = FCS;
          cnt_next   = 4'd0;
        end else begin
          pay_cnt_next = pay_cnt_reg + 11'd1;
        end
      end
      FCS: begin
        if (cnt_reg == 4'd3) begin
          state_next       = IFG;
          cnt_next         = 4'd0;
          frames_sent_next = frames_sent_reg + 16'd1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ABORT: begin
        frames_aborted_next = frames_aborted_reg + 16'd1;
        state_next          = last_seen_reg ? IFG : DRAIN;
        cnt_next            = 4'd0;
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_next = IFG;
          cnt_next   = 4'd0;
        end
      end
      IFG: begin
        // 11 gap cycles here; the IDLE cycle that follows is the 12th idle byte.
        if (cnt_reg == 4'd10) state_next = IDLE;
        else                  cnt_next   = cnt_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fcs = ~crc_next;

  // GMII outputs are registered from the next-state view so they line up with state_reg.
  always_comb begin
    gmii_txd_next   = 8'h00;
    gmii_tx_en_next = 1'b0;
    gmii_tx_er_next = 1'b0;
    case (state_next)
      PREAMBLE: begin
        gmii_txd_next   = 8'h55;
        gmii_tx_en_next = 1'b1;
      end
      SFD: begin
        gmii_txd_next   = 8'hD5;
        gmii_tx_en_next = 1'b1;
      end
      HEADER: begin
        gmii_txd_next   = hdr_byte(cnt_next, mac_dst_next, mac_src_next);
        gmii_tx_en_next = 1'b1;
      end
      PAYLOAD: begin
        gmii_txd_next   = word_byte(hold_next, byte_idx_next);
        gmii_tx_en_next = 1'b1;
      end
      PAD: gmii_tx_en_next = 1'b1;
      FCS: begin
        gmii_tx_en_next = 1'b1;
        case (cnt_next[1:0])
          2'd0:    gmii_txd_next = fcs[7:0];
          2'd1:    gmii_txd_next = fcs[15:8];
          2'd2:    gmii_txd_next = fcs[23:16];
          default: gmii_txd_next = fcs[31:24];
        endcase
      end
      ABORT: begin
        gmii_tx_en_next = 1'b1;
        gmii_tx_er_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      cnt_reg            <= 4'd0;
      byte_idx_reg       <= 2'd0;
      hold_reg           <= 32'h0;
      hold_last_reg      <= 1'b0;
      hold_lb_reg        <= 2'd0;
      pay_cnt_reg        <= 11'd0;
      last_seen_reg      <= 1'b0;
      mac_dst_reg        <= 48'h0;
      mac_src_reg        <= 48'h0;
      crc_reg            <= 32'hFFFFFFFF;
      frames_sent_reg    <= 16'd0;
      frames_aborted_reg <= 16'd0;
      gmii_txd_reg       <= 8'h00;
      gmii_tx_en_reg     <= 1'b0;
      gmii_tx_er_reg     <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      byte_idx_reg       <= byte_idx_next;
      hold_reg           <= hold_next;
      hold_last_reg      <= hold_last_next;
      hold_lb_reg        <= hold_lb_next;
      pay_cnt_reg        <= pay_cnt_next;
      last_seen_reg      <= last_seen_next;
      mac_dst_reg        <= mac_dst_next;
      mac_src_reg        <= mac_src_next;
      crc_reg            <= crc_next;
      frames_sent_reg    <= frames_sent_next;
      frames_aborted_reg <= frames_aborted_next;
      gmii_txd_reg       <= gmii_txd_next;
      gmii_tx_en_reg     <= gmii_tx_en_next;
      gmii_tx_er_reg     <= gmii_tx_er_next;
    end
  end

  assign gmii_txd       = gmii_txd_reg;
  assign gmii_tx_en     = gmii_tx_en_reg;
  assign gmii_tx_er     = gmii_tx_er_reg;
  assign frames_sent    = frames_sent_reg;
  assign frames_aborted = frames_aborted_reg;

endmodule
